// File: rtl/dm_pipe_pkg.sv
// dm_pipe_pkg: shared access-type codes, error codes, FSM state type and
// small helpers used by the dm_pipe data memory and its lane formatter.
//   dm_* access codes : word / halfword / halfword unsigned / byte / byte unsigned
//   dm_err_* codes    : none / misaligned / out of range / bad type
package dm_pipe_pkg;

    // Access types, identical to the codes used by the CPU control decoder.
    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

    // Response error codes.
    localparam logic [1:0] DM_ERR_NONE     = 2'd0;
    localparam logic [1:0] DM_ERR_MISALIGN = 2'd1;
    localparam logic [1:0] DM_ERR_RANGE    = 2'd2;
    localparam logic [1:0] DM_ERR_TYPE     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    // Only the five dm_* codes are legal; 3'b101..3'b111 are bad types.
    function automatic logic dm_type_ok(input logic [2:0] t);
        return (t <= DM_BYTE_UNSIGNED);
    endfunction

    // Access size in bytes. Bad types report 1 so the range arithmetic
    // stays well defined; they are rejected before range matters.
    function automatic logic [2:0] dm_size(input logic [2:0] t);
        case (t)
            DM_WORD:                           return 3'd4;
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: return 3'd2;
            default:                           return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// dm_lane_fmt: combinational byte-lane formatter for the data memory.
//   Store side: dm_type_i, byte_off_i, wdata_i -> be_o (byte enables) and
//               wword_o (right-aligned store data replicated onto its lanes).
//   Load side : dm_type_i, byte_off_i, rword_i -> rdata_o (selected lane(s),
//               sign- or zero-extended to 32 bits).
// Unknown access types produce zero enables and zero load data.
module dm_lane_fmt
    import dm_pipe_pkg::*;
(
    input  logic [2:0]  dm_type_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);

    logic [31:0] rshift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian: byte lane n occupies bits [8n+7:8n].
    assign rshift   = rword_i >> {byte_off_i, 3'b000};
    assign byte_sel = rshift[7:0];
    assign half_sel = byte_off_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        be_o    = 4'b0000;
        wword_o = 32'h0;
        rdata_o = 32'h0;
        case (dm_type_i)
            DM_WORD: begin
                be_o    = 4'b1111;
                wword_o = wdata_i;
                rdata_o = rword_i;
            end
            DM_HALFWORD: begin
                be_o    = byte_off_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{half_sel[15]}}, half_sel};
            end
            DM_HALFWORD_UNSIGNED: begin
                be_o    = byte_off_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
                rdata_o = {16'h0, half_sel};
            end
            DM_BYTE: begin
                be_o    = 4'b0001 << byte_off_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{byte_sel[7]}}, byte_sel};
            end
            DM_BYTE_UNSIGNED: begin
                be_o    = 4'b0001 << byte_off_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = {24'h0, byte_sel};
            end
            default: begin
                be_o    = 4'b0000;
                wword_o = 32'h0;
                rdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dm_pipe.sv
// dm_pipe: word-organised little-endian data memory with a valid/ready
// request port and a fixed, parameterised response latency.
//   clk, rstn         : clock (rising edge), synchronous active-low reset
//   req_valid/ready   : request handshake
//   req_wr, addr,
//   wdata, DMType     : request fields, sampled only at acceptance
//   resp_valid        : one-cycle response strobe
//   rdata, err        : response data / error code, held outside RESP
//   dbg_state         : current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_ready=1 (req_ready is 1 exactly in IDLE). Requests seen while busy are
// not queued; the requester keeps req_valid high until it is accepted.
// Stores commit on the acceptance edge; loads read the word on that edge.
module dm_pipe
    import dm_pipe_pkg::*;
#(
    parameter int                    DEPTH_WORDS = 64,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    LATENCY     = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [2:0]            DMType,
    output logic                  resp_valid,
    output logic [31:0]           rdata,
    output logic [1:0]            err,
    output dm_state_e             dbg_state
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Counter holds at most LATENCY-2.
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [ADDR_WIDTH:0] BYTES = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);

    dm_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      res_rdata_q, res_rdata_d;  // result captured at acceptance
    logic [1:0]       res_err_q, res_err_d;
    logic [31:0]      rdata_q, rdata_d;          // presented result
    logic [1:0]       err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic                  accept;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH:0]   end_off;
    logic [2:0]            size;
    logic [1:0]            err_c;
    logic [IDX_W-1:0]      word_idx;
    logic [31:0]           rword;
    logic [3:0]            be;
    logic [31:0]           wword;
    logic [31:0]           load_data;
    logic [31:0]           result_c;

    assign accept = (state_q == ST_IDLE) && req_valid;

    // Offset is unsigned and wraps, so addresses below BASE_ADDR land far
    // above the array. end_off carries one extra bit so that wrap cannot
    // make an out-of-range access look legal.
    assign offset   = addr - BASE_ADDR;
    assign size     = dm_size(DMType);
    assign end_off  = {1'b0, offset} + {{(ADDR_WIDTH - 2){1'b0}}, size};
    assign word_idx = offset[IDX_W+1:2];

    // Classification priority: bad type, then range, then alignment.
    always_comb begin
        err_c = DM_ERR_NONE;
        if (!dm_type_ok(DMType)) begin
            err_c = DM_ERR_TYPE;
        end else if (end_off > BYTES) begin
            err_c = DM_ERR_RANGE;
        end else if (((size == 3'd2) && addr[0]) ||
                     ((size == 3'd4) && (addr[1:0] != 2'b00))) begin
            err_c = DM_ERR_MISALIGN;
        end
    end

    assign rword = mem_q[word_idx];

    dm_lane_fmt u_lane_fmt (
        .dm_type_i  (DMType),
        .byte_off_i (addr[1:0]),
        .wdata_i    (wdata),
        .rword_i    (rword),
        .be_o       (be),
        .wword_o    (wword),
        .rdata_o    (load_data)
    );

    // Stores and faults return zero data.
    assign result_c = (!req_wr && (err_c == DM_ERR_NONE)) ? load_data : 32'h0;

    // Word array: not reset; lanes outside the byte enable keep their value.
    always_ff @(posedge clk) begin
        if (rstn && accept && req_wr && (err_c == DM_ERR_NONE)) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            res_rdata_q <= 32'h0;
            res_err_q   <= DM_ERR_NONE;
            rdata_q     <= 32'h0;
            err_q       <= DM_ERR_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_rdata_q <= res_rdata_d;
            res_err_q   <= res_err_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // rdata/err only change on the edge entering RESP, so they hold their
    // previous values through WAIT and after the response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_rdata_d = res_rdata_q;
        res_err_d   = res_err_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    res_rdata_d = result_c;
                    res_err_d   = err_c;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        rdata_d = result_c;
                        err_d   = err_c;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    rdata_d = res_rdata_q;
                    err_d   = res_err_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign rdata      = rdata_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dm_pipe.sv
// Directed bench for dm_pipe. Three instances share the request inputs:
//   u_a : LATENCY=1, BASE_ADDR=0,      DEPTH_WORDS=64
//   u_b : LATENCY=4, BASE_ADDR=0,      DEPTH_WORDS=64
//   u_c : LATENCY=1, BASE_ADDR=0x1000, DEPTH_WORDS=4
// "sel" picks which instance sees req_valid and whose outputs are observed.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_dm_pipe;
    import dm_pipe_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        req_valid_s;
    logic        req_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dmtype;
    int          sel;

    logic        rv_a, rv_b, rv_c;
    logic        ready_a, ready_b, ready_c;
    logic        resp_a, resp_b, resp_c;
    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic [1:0]  err_a, err_b, err_c;
    dm_state_e   st_a, st_b, st_c;

    logic        ready_m, resp_m;
    logic [31:0] rdata_m;
    logic [1:0]  err_m;
    dm_state_e   st_m;

    assign rv_a = req_valid_s && (sel == 0);
    assign rv_b = req_valid_s && (sel == 1);
    assign rv_c = req_valid_s && (sel == 2);

    always_comb begin
        ready_m = ready_a; resp_m = resp_a; rdata_m = rdata_a; err_m = err_a; st_m = st_a;
        if (sel == 1) begin
            ready_m = ready_b; resp_m = resp_b; rdata_m = rdata_b; err_m = err_b; st_m = st_b;
        end else if (sel == 2) begin
            ready_m = ready_c; resp_m = resp_c; rdata_m = rdata_c; err_m = err_c; st_m = st_c;
        end
    end

    dm_pipe #(.DEPTH_WORDS(64), .ADDR_WIDTH(32), .BASE_ADDR(32'h0), .LATENCY(1)) u_a (
        .clk(clk), .rstn(rstn), .req_valid(rv_a), .req_ready(ready_a), .req_wr(req_wr),
        .addr(addr), .wdata(wdata), .DMType(dmtype), .resp_valid(resp_a),
        .rdata(rdata_a), .err(err_a), .dbg_state(st_a));

    dm_pipe #(.DEPTH_WORDS(64), .ADDR_WIDTH(32), .BASE_ADDR(32'h0), .LATENCY(4)) u_b (
        .clk(clk), .rstn(rstn), .req_valid(rv_b), .req_ready(ready_b), .req_wr(req_wr),
        .addr(addr), .wdata(wdata), .DMType(dmtype), .resp_valid(resp_b),
        .rdata(rdata_b), .err(err_b), .dbg_state(st_b));

    dm_pipe #(.DEPTH_WORDS(4), .ADDR_WIDTH(32), .BASE_ADDR(32'h1000), .LATENCY(1)) u_c (
        .clk(clk), .rstn(rstn), .req_valid(rv_c), .req_ready(ready_c), .req_wr(req_wr),
        .addr(addr), .wdata(wdata), .DMType(dmtype), .resp_valid(resp_c),
        .rdata(rdata_c), .err(err_c), .dbg_state(st_c));

    // ---------------- checking ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Entered just after a falling edge; returns just after the falling edge
    // that follows the response cycle (DUT back in IDLE).
    // lat = rising edges from acceptance (inclusive) until resp_valid is seen.
    task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] t, output logic [31:0] rd,
                        output logic [1:0] er, output int lat);
        int n;
        req_valid_s = 1'b1;
        req_wr      = wr;
        addr        = a;
        wdata       = wd;
        dmtype      = t;
        n = 0;
        while (!ready_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid_s = 1'b0;
        lat = 1;
        while (!resp_m && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = rdata_m;
        er = err_m;
        @(negedge clk);
    endtask

    task automatic xchk(input string tag, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] t,
                        input logic [31:0] exp_rd, input logic [1:0] exp_err,
                        input int exp_lat);
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        xact(wr, a, wd, t, rd, er, lat);
        chk({tag, "_lat"},   32'(lat), 32'(exp_lat));
        chk({tag, "_err"},   32'(er),  32'(exp_err));
        chk({tag, "_rdata"}, rd,       exp_rd);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rstn        = 1'b0;
        req_valid_s = 1'b0;
        req_wr      = 1'b0;
        addr        = 32'h0;
        wdata       = 32'h0;
        dmtype      = DM_WORD;
        sel         = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_m), 32'd0);
        chk("rst_req_ready",  32'(ready_m), 32'd1);
        chk("rst_rdata",      rdata_m, 32'h0);
        chk("rst_err",        32'(err_m), 32'd0);
        chk("rst_state",      32'(st_m), 32'(ST_IDLE));
        rstn = 1'b1;
        @(negedge clk);

        // Word round trip and extension on u_a (LATENCY=1).
        xchk("sw_10",  1'b1, 32'h10, 32'h8040_20F1, DM_WORD, 32'h0, DM_ERR_NONE, 1);
        xchk("lw_10",  1'b0, 32'h10, 32'h0, DM_WORD, 32'h8040_20F1, DM_ERR_NONE, 1);
        xchk("lb_13",  1'b0, 32'h13, 32'h0, DM_BYTE, 32'hFFFF_FF80, DM_ERR_NONE, 1);
        xchk("lbu_13", 1'b0, 32'h13, 32'h0, DM_BYTE_UNSIGNED, 32'h0000_0080, DM_ERR_NONE, 1);
        xchk("lh_12",  1'b0, 32'h12, 32'h0, DM_HALFWORD, 32'hFFFF_8040, DM_ERR_NONE, 1);
        xchk("lhu_10", 1'b0, 32'h10, 32'h0, DM_HALFWORD_UNSIGNED, 32'h0000_20F1, DM_ERR_NONE, 1);
        xchk("lb_10",  1'b0, 32'h10, 32'h0, DM_BYTE, 32'hFFFF_FFF1, DM_ERR_NONE, 1);
        xchk("sb_11",  1'b1, 32'h11, 32'h1234_56AA, DM_BYTE, 32'h0, DM_ERR_NONE, 1);
        xchk("lw_10b", 1'b0, 32'h10, 32'h0, DM_WORD, 32'h8040_AAF1, DM_ERR_NONE, 1);
        xchk("sh_12",  1'b1, 32'h12, 32'hFFFF_1357, DM_HALFWORD, 32'h0, DM_ERR_NONE, 1);
        xchk("lw_10c", 1'b0, 32'h10, 32'h0, DM_WORD, 32'h1357_AAF1, DM_ERR_NONE, 1);

        // Faults: error code, zero data, memory untouched.
        xchk("lw_12_mis",  1'b0, 32'h12,  32'h0, DM_WORD, 32'h0, DM_ERR_MISALIGN, 1);
        xchk("sh_13_mis",  1'b1, 32'h13,  32'hBEEF, DM_HALFWORD, 32'h0, DM_ERR_MISALIGN, 1);
        xchk("sw_11_mis",  1'b1, 32'h11,  32'hDEAD_BEEF, DM_WORD, 32'h0, DM_ERR_MISALIGN, 1);
        xchk("lw_100_rng", 1'b0, 32'h100, 32'h0, DM_WORD, 32'h0, DM_ERR_RANGE, 1);
        xchk("lh_ff_rng",  1'b0, 32'hFF,  32'h0, DM_HALFWORD, 32'h0, DM_ERR_RANGE, 1);
        xchk("bad_type",   1'b1, 32'h101, 32'h0, 3'b111, 32'h0, DM_ERR_TYPE, 1);
        xchk("bad_type5",  1'b0, 32'h10,  32'h0, 3'b101, 32'h0, DM_ERR_TYPE, 1);
        xchk("lw_10_kept", 1'b0, 32'h10,  32'h0, DM_WORD, 32'h1357_AAF1, DM_ERR_NONE, 1);

        // Top-of-array boundary stays legal.
        xchk("sh_fe",  1'b1, 32'hFE, 32'h0000_CAFE, DM_HALFWORD, 32'h0, DM_ERR_NONE, 1);
        xchk("sb_fc",  1'b1, 32'hFC, 32'h0000_0011, DM_BYTE, 32'h0, DM_ERR_NONE, 1);
        xchk("sb_fd",  1'b1, 32'hFD, 32'h0000_0022, DM_BYTE, 32'h0, DM_ERR_NONE, 1);
        xchk("lw_fc",  1'b0, 32'hFC, 32'h0, DM_WORD, 32'hCAFE_2211, DM_ERR_NONE, 1);
        xchk("lhu_fe", 1'b0, 32'hFE, 32'h0, DM_HALFWORD_UNSIGNED, 32'h0000_CAFE, DM_ERR_NONE, 1);

        // Latency and handshake on u_b (LATENCY=4).
        sel = 1;
        req_valid_s = 1'b1;
        req_wr      = 1'b1;
        addr        = 32'h40;
        wdata       = 32'h1234_5678;
        dmtype      = DM_WORD;
        chk("hs_ready_pre", 32'(ready_m), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Second request (load of the same word) held through the busy period.
        req_wr = 1'b0;
        wdata  = 32'h0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("hs_ready_busy%0d", k), 32'(ready_m), 32'd0);
            chk($sformatf("hs_resp%0d", k), 32'(resp_m), (k == 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk("hs_ready_back", 32'(ready_m), 32'd1);
        chk("hs_resp_done",  32'(resp_m),  32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid_s = 1'b0;
        chk("hs2_accepted", 32'(ready_m), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("hs2_resp%0d", k), 32'(resp_m), 32'd0);
            chk($sformatf("hs2_hold%0d", k), rdata_m, 32'h0);
            @(negedge clk);
        end
        chk("hs2_resp4", 32'(resp_m), 32'd1);
        chk("hs2_rdata", rdata_m, 32'h1234_5678);
        chk("hs2_err",   32'(err_m), 32'd0);
        @(negedge clk);
        chk("hs2_idle", 32'(st_m), 32'(ST_IDLE));
        chk("hs2_rdata_held", rdata_m, 32'h1234_5678);

        xchk("b_lbu_43", 1'b0, 32'h43, 32'h0, DM_BYTE_UNSIGNED, 32'h0000_0012, DM_ERR_NONE, 4);

        // Reset in the middle of a LATENCY=4 store.
        req_valid_s = 1'b1;
        req_wr      = 1'b1;
        addr        = 32'h20;
        wdata       = 32'h5555_5555;
        dmtype      = DM_WORD;
        @(posedge clk);
        @(negedge clk);
        req_valid_s = 1'b0;
        chk("mid_resp1", 32'(resp_m), 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        chk("mid_resp2", 32'(resp_m), 32'd0);
        @(negedge clk);
        chk("mid_resp3",  32'(resp_m), 32'd0);
        chk("mid_state3", 32'(st_m), 32'(ST_IDLE));
        @(negedge clk);
        chk("mid_resp4", 32'(resp_m), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_resp5",  32'(resp_m), 32'd0);
        chk("mid_ready5", 32'(ready_m), 32'd1);
        chk("mid_state5", 32'(st_m), 32'(ST_IDLE));
        xchk("b_lw_20", 1'b0, 32'h20, 32'h0, DM_WORD, 32'h5555_5555, DM_ERR_NONE, 4);

        // Base address and small array on u_c.
        sel = 2;
        xchk("c_sw_100c",  1'b1, 32'h100C, 32'hA1B2_C3D4, DM_WORD, 32'h0, DM_ERR_NONE, 1);
        xchk("c_lw_1010",  1'b0, 32'h1010, 32'h0, DM_WORD, 32'h0, DM_ERR_RANGE, 1);
        xchk("c_lw_0ffc",  1'b0, 32'h0FFC, 32'h0, DM_WORD, 32'h0, DM_ERR_RANGE, 1);
        xchk("c_lbu_100f", 1'b0, 32'h100F, 32'h0, DM_BYTE_UNSIGNED, 32'h0000_00A1, DM_ERR_NONE, 1);
        xchk("c_lh_100c",  1'b0, 32'h100C, 32'h0, DM_HALFWORD, 32'hFFFF_C3D4, DM_ERR_NONE, 1);
        xchk("c_sw_1000",  1'b1, 32'h1000, 32'h0BAD_F00D, DM_WORD, 32'h0, DM_ERR_NONE, 1);
        xchk("c_lw_1000",  1'b0, 32'h1000, 32'h0, DM_WORD, 32'h0BAD_F00D, DM_ERR_NONE, 1);
        xchk("c_lw_100c",  1'b0, 32'h100C, 32'h0, DM_WORD, 32'hA1B2_C3D4, DM_ERR_NONE, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dm_pipe.md
Name: dm_pipe

Overview:
- Parametrised successor to the single-cycle byte-array data memory used by the pipelined CPU's MEM stage.
- Word-organised, little-endian, with 4 byte lanes, and a configurable byte depth and base address.
- Requests use a valid/ready handshake; responses come back after a programmable number of cycles, so the pipeline's stall logic can be exercised.
- Checks the access type, address range and alignment; a faulting access returns an error code instead of touching memory.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored (≥1).
- ADDR_WIDTH, 32, width of the byte address port.
- BASE_ADDR, 0, byte address mapped to word 0 (word-aligned).
- LATENCY, 1, rising edges from request acceptance to the response cycle (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_wr  in  1  1 = store, 0 = load.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  32  store data, right-aligned.
- DMType  in  3  access type, using the shared dm_* codes.
- resp_valid  out  1  one-cycle response strobe.
- rdata  out  32  load result, extended per DMType; 0 for stores and errors.
- err  out  2  0 OK, 1 misaligned, 2 out of range, 3 bad type; meaningful only when resp_valid=1.

Behaviour:
- Reset:
  - Sampled on a clk edge while rstn=0: state becomes IDLE, counter=0, resp_valid=0, rdata=0, err=0, req_ready=1 in the following cycle.
  - The memory array is not reset.
- States: IDLE, WAIT, RESP.
  - req_ready=1 only in IDLE.
  - A request is accepted on an edge where IDLE, req_valid=1 and rstn=1.
- Acceptance edge:
  - Register the request and classify it. Priority: bad type (DMType not one of the five dm_* codes) > out of range > misaligned.
  - Out of range: offset = addr-BASE_ADDR (unsigned, ADDR_WIDTH bits), and offset+size > DEPTH_WORDS*4. Size is 1, 2 or 4 bytes.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
- Legal store:
  - Memory is updated at the acceptance edge, on byte lanes only. Byte writes lane addr[1:0]; halfword writes lanes addr[1]*2 and +1; word writes all 4 lanes.
  - Lanes not written keep their old value.
- Legal load:
  - The word is read at the acceptance edge; the selected lane(s) are extracted and sign- or zero-extended per DMType, then held.
- Faulting request: no memory access; rdata=0.
- Timing:
  - LATENCY=1: go to RESP.
  - LATENCY>1: go to WAIT with counter=LATENCY-2, decrement each cycle, go to RESP when counter=0.
  - RESP: resp_valid=1, rdata and err valid for exactly one cycle, then back to IDLE.
  - resp_valid rises in the cycle following the LATENCY-th edge after acceptance. Throughput is one request per LATENCY+1 cycles.
- Outside RESP: resp_valid=0; rdata and err hold their last values.
- req_valid while busy: ignored and not queued; the requester must hold it until req_ready=1.
- Load after store to the same word: returns the new data, since the store committed earlier.
- rstn=0 during WAIT or RESP:
  - The pending response is dropped (no resp_valid); IDLE next cycle.
  - A store that was already accepted stays committed.
- Inputs other than req_valid are sampled only at acceptance.

Decomposition:
- Shared defines file (ctrl_encode_def.v), alongside the existing dm_* codes:
  - dm_word=3'b000, dm_halfword=3'b001, dm_halfword_unsigned=3'b010, dm_byte=3'b011, dm_byte_unsigned=3'b100.
  - New error codes dm_err_none/misalign/range/type = 0..3.
- Sub-module dm_lane_fmt (combinational):
  - Store side: produces the 4-bit byte enable and the lane-shifted write word.
  - Load side: extracts and extends the load result.
- dm_pipe contains the FSM, counter, request registers and word array.

Test Plan:
- Reset and word round trip. LATENCY=1, BASE_ADDR=0. Hold rstn=0 for 2 cycles: resp_valid=0, req_ready=1. Store word 0x8040_20F1 at 0x10 → resp_valid 1 cycle after acceptance, err=0, rdata=0. Load word at 0x10 → rdata=0x8040_20F1.
- Extension. After the store above:
  - lb 0x13 → 0xFFFF_FF80; lbu 0x13 → 0x0000_0080.
  - lh 0x12 → 0xFFFF_8040; lhu 0x10 → 0x0000_20F1.
  - sb 0xAA to 0x11, then lw 0x10 → 0x8040_AAF1.
- Faults, each with err checked and memory left unchanged:
  - lw 0x12 → err=1.
  - sh 0x13 → err=1.
  - lw DEPTH_WORDS*4 → err=2.
  - DMType=3'b111 at a misaligned, out-of-range address → err=3.
- Latency and handshake. LATENCY=4: resp_valid exactly 4 edges after acceptance, for one cycle. req_ready=0 for those 4 cycles; a second req_valid held throughout is accepted on the first edge after req_ready returns to 1.
- Reset mid-operation. LATENCY=4, sw 0x5555_5555 to 0x20, then rstn=0 two cycles later → no resp_valid, IDLE. Afterwards lw 0x20 → 0x5555_5555.
- Base and range. BASE_ADDR=0x1000, DEPTH_WORDS=4:
  - sw 0x100C → err=0.
  - lw 0x1010 → err=2.
  - lw 0x0FFC → err=2 (wraps as unsigned).
  - lbu 0x100F → the top byte of the last word.
